// File: rtl/issue_scoreboard_pkg.sv
// Shared issue-stage definitions: pipe indices, default sizes and latencies,
// and the ID-to-issue request bundle.
package issue_scoreboard_pkg;

  localparam int SB_NUM_REGS  = 32;
  localparam int SB_REG_W     = $clog2(SB_NUM_REGS);
  localparam int SB_NUM_PIPES = 2;
  localparam int SB_MAX_LAT   = 7;

  localparam int EXE_PIPE_ALU_BIT = 0;
  localparam int EXE_PIPE_LSU_BIT = 1;

  // Entry p (4 bits each) is cycles from dispatch-register load to WB for pipe p.
  localparam logic [SB_NUM_PIPES*4-1:0] SB_PIPE_LAT = {4'd3, 4'd1};

  typedef struct packed {
    logic                    valid;
    logic [SB_NUM_PIPES-1:0] pipe;
    logic [SB_REG_W-1:0]     rd;
    logic [SB_REG_W-1:0]     a1;
    logic [SB_REG_W-1:0]     a2;
    logic                    use_a1;
    logic                    use_a2;
    logic                    reg_write;
  } issue_req_t;

endpackage

// File: rtl/issue_scoreboard_wb_slot_tracker.sv
// Write-back port reservation calendar: slot[k] means a WB is booked k cycles from now.
// One-cycle update; a reservation at lat lands in slot[lat] and shifts down each cycle.
module issue_scoreboard_wb_slot_tracker #(
  parameter int MAX_LAT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reserve,
  input  logic [3:0]         lat,
  output logic [MAX_LAT+1:1] slot
);

  logic [MAX_LAT+1:1] slot_nxt;

  always_comb begin
    slot_nxt = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      slot_nxt[k] = slot[k+1];
    end
    for (int k = 1; k <= MAX_LAT + 1; k++) begin
      if (reserve && (int'(lat) == k)) begin
        slot_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else begin
      slot <= slot_nxt;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Single-issue stage: RAW/WAW, structural and WB-port hazard checks, one registered dispatch per cycle.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle WB clear satisfy RAW/WAW checks.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int                     NUM_REGS  = SB_NUM_REGS,
  parameter int                     NUM_PIPES = SB_NUM_PIPES,
  parameter int                     MAX_LAT   = SB_MAX_LAT,
  parameter logic [NUM_PIPES*4-1:0] PIPE_LAT  = SB_PIPE_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic [NUM_PIPES-1:0]        id_pipe,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd,
  input  logic [$clog2(NUM_REGS)-1:0] id_a1,
  input  logic [$clog2(NUM_REGS)-1:0] id_a2,
  input  logic                        id_use_a1,
  input  logic                        id_use_a2,
  input  logic                        id_reg_write,
  input  logic [NUM_PIPES-1:0]        pipe_ready,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
  output logic                        issue_ready,
  output logic [NUM_PIPES-1:0]        disp_valid,
  output logic [$clog2(NUM_REGS)-1:0] disp_rd,
  output logic [NUM_REGS-1:0]         sb_pending
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_chk;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [MAX_LAT+1:1]  slot;
  logic [3:0]          sel_lat;
  logic                wr;
  logic                raw_haz;
  logic                waw_haz;
  logic                struct_haz;
  logic                wb_busy;
  logic                fire;

  // id_pipe is one-hot, so OR-ing the latency fields selects the target pipe's latency.
  always_comb begin
    sel_lat = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (id_pipe[p]) begin
        sel_lat = sel_lat | PIPE_LAT[p*4 +: 4];
      end
    end
  end

  // Dispatch register adds one cycle, so this instruction's WB lands at slot[L+1].
  always_comb begin
    wb_busy = 1'b0;
    for (int k = 1; k <= MAX_LAT + 1; k++) begin
      if (k == int'(sel_lat) + 1) begin
        wb_busy = slot[k];
      end
    end
  end

  assign clr = wb_en ? (NUM_REGS'(1) << wb_rd) : '0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign pend_chk = pending & ~clr;
`else
  assign pend_chk = pending;
`endif

  assign wr          = id_reg_write && (id_rd != '0);
  assign raw_haz     = (id_use_a1 && pend_chk[id_a1]) || (id_use_a2 && pend_chk[id_a2]);
  assign waw_haz     = wr && pend_chk[id_rd];
  assign struct_haz  = |(id_pipe & ~pipe_ready);
  assign issue_ready = !(raw_haz || waw_haz || struct_haz || (wr && wb_busy));
  assign fire        = id_valid && issue_ready && !flush;
  assign set         = (fire && wr) ? (NUM_REGS'(1) << id_rd) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      disp_valid <= '0;
      disp_rd    <= '0;
    end else begin
      pending    <= (pending & ~clr) | set;
      disp_valid <= fire ? id_pipe : '0;
      if (fire) begin
        disp_rd <= id_rd;
      end
    end
  end

  assign sb_pending = pending;

  issue_scoreboard_wb_slot_tracker #(
    .MAX_LAT (MAX_LAT)
  ) u_wb_slot_tracker (
    .clk     (clk),
    .rst     (rst),
    .reserve (fire && wr),
    .lat     (sel_lat),
    .slot    (slot)
  );

  a_pipe_onehot: assert property (@(posedge clk) disable iff (rst) id_valid |-> $onehot(id_pipe));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic against a calendar-based model.
// The bench also plays the execution pipes, returning WB for each dispatched writer.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int LAT_ALU = 1;
  localparam int LAT_LSU = 3;
  localparam logic [1:0] ALU = 2'b01;
  localparam logic [1:0] LSU = 2'b10;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_use_a1, id_use_a2, id_reg_write, wb_en;
  logic [1:0]  id_pipe, pipe_ready;
  logic [4:0]  id_rd, id_a1, id_a2, wb_rd;
  logic        issue_ready;
  logic [1:0]  disp_valid;
  logic [4:0]  disp_rd;
  logic [31:0] sb_pending;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic obs_ready;

  // Model: pending set, WB-port bookings by absolute cycle, and the pipes' WB calendar.
  bit   m_pend[32];
  bit   m_busy[int];
  int   pipe_wb[int];
  logic [1:0] m_dv;
  logic [4:0] m_drd;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pipe(id_pipe),
    .id_rd(id_rd), .id_a1(id_a1), .id_a2(id_a2), .id_use_a1(id_use_a1),
    .id_use_a2(id_use_a2), .id_reg_write(id_reg_write), .pipe_ready(pipe_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .issue_ready(issue_ready), .disp_valid(disp_valid),
    .disp_rd(disp_rd), .sb_pending(sb_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic issue_req_t mk(input logic v, input logic [1:0] p, input int rd,
                                    input int a1, input int a2, input logic u1,
                                    input logic u2, input logic rw);
    issue_req_t q;
    q.valid = v; q.pipe = p; q.rd = 5'(rd); q.a1 = 5'(a1); q.a2 = 5'(a2);
    q.use_a1 = u1; q.use_a2 = u2; q.reg_write = rw;
    return q;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  function automatic bit pend_eff(input int r, input bit wen, input int wrd);
    return m_pend[r] && !(BYP && wen && (wrd == r));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_busy.delete();
    m_dv  = '0;
    m_drd = '0;
  endtask

  // One clock cycle: drive at posedge+1, check issue_ready mid-cycle, check registered outputs after the edge.
  task automatic step(input issue_req_t q, input logic [1:0] prdy, input logic fl);
    int L, wrd;
    bit wen, wr, hz, rdy, fire;
    wen = pipe_wb.exists(cyc);
    wrd = wen ? pipe_wb[cyc] : 0;
    if (wen) pipe_wb.delete(cyc);
    id_valid = q.valid; id_pipe = q.pipe; id_rd = q.rd; id_a1 = q.a1; id_a2 = q.a2;
    id_use_a1 = q.use_a1; id_use_a2 = q.use_a2; id_reg_write = q.reg_write;
    pipe_ready = prdy; flush = fl; wb_en = wen; wb_rd = 5'(wrd);

    L  = q.pipe[EXE_PIPE_LSU_BIT] ? LAT_LSU : LAT_ALU;
    wr = q.reg_write && (q.rd != 0);
    hz = (q.use_a1 && pend_eff(int'(q.a1), wen, wrd)) ||
         (q.use_a2 && pend_eff(int'(q.a2), wen, wrd)) ||
         (wr && pend_eff(int'(q.rd), wen, wrd)) ||
         ((q.pipe & ~prdy) != 2'b00) ||
         (wr && m_busy.exists(cyc + 1 + L));
    rdy  = !hz;
    fire = q.valid && rdy && !fl;

    #2;
    obs_ready = issue_ready;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});

    if (wen) m_pend[wrd] = 1'b0;
    if (fire && wr) begin
      m_pend[q.rd]           = 1'b1;
      m_busy[cyc + 1 + L]    = 1'b1;
      pipe_wb[cyc + 1 + L]   = int'(q.rd);
    end
    m_dv = fire ? q.pipe : 2'b00;
    if (fire) m_drd = q.rd;

    @(posedge clk);
    #1;
    cyc++;
    chk("disp_valid", {30'd0, disp_valid}, {30'd0, m_dv});
    chk("disp_rd",    {27'd0, disp_rd},    {27'd0, m_drd});
    chk("sb_pending", sb_pending, pend_vec());
  endtask

  task automatic idle();
    step(mk(1'b0, ALU, 0, 0, 0, 1'b0, 1'b0, 1'b0), 2'b11, 1'b0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_disp_valid"}, {30'd0, disp_valid}, 32'd0);
    chk({tag, "_disp_rd"},    {27'd0, disp_rd},    32'd0);
    chk({tag, "_pending"},    sb_pending,          32'd0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    issue_req_t q;
    logic [1:0] prdy;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_pipe = ALU; id_rd = '0; id_a1 = '0;
    id_a2 = '0; id_use_a1 = 1'b0; id_use_a2 = 1'b0; id_reg_write = 1'b0;
    pipe_ready = 2'b00; wb_en = 1'b0; wb_rd = '0;
    model_reset();

    // Reset state; readiness depends only on pipe_ready.
    @(posedge clk);
    #1;
    chk("rst_disp_valid", {30'd0, disp_valid}, 32'd0);
    chk("rst_disp_rd",    {27'd0, disp_rd},    32'd0);
    chk("rst_pending",    sb_pending,          32'd0);
    #1;
    chk("rst_ready_blocked", {31'd0, issue_ready}, 32'd0);
    pipe_ready = 2'b11;
    #1;
    chk("rst_ready_free", {31'd0, issue_ready}, 32'd1);
    rst = 1'b0;

    // First issue: reads x5, nothing pending.
    step(mk(1'b1, ALU, 1, 5, 0, 1'b1, 1'b0, 1'b0), 2'b11, 1'b0);
    chk("first_ready", {31'd0, obs_ready}, 32'd1);
    chk("first_disp",  {30'd0, disp_valid}, 32'd1);

    // ALU writes x5; consumer stalls until its WB.
    step(mk(1'b1, ALU, 5, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    chk("x5_pending", {31'd0, sb_pending[5]}, 32'd1);
    step(mk(1'b1, ALU, 0, 5, 0, 1'b1, 1'b0, 1'b0), 2'b11, 1'b0);
    chk("raw_stall", {31'd0, obs_ready}, 32'd0);
    step(mk(1'b1, ALU, 0, 5, 0, 1'b1, 1'b0, 1'b0), 2'b11, 1'b0);
    chk("raw_wb_cycle", {31'd0, obs_ready}, {31'd0, BYP});
    if (!BYP) begin
      step(mk(1'b1, ALU, 0, 5, 0, 1'b1, 1'b0, 1'b0), 2'b11, 1'b0);
      chk("raw_after_wb", {31'd0, obs_ready}, 32'd1);
    end

    // LSU x6 then ALU x7 two cycles later collide at WB.
    step(mk(1'b1, LSU, 6, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    idle();
    step(mk(1'b1, ALU, 7, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    chk("wb_collide_stall", {31'd0, obs_ready}, 32'd0);
    step(mk(1'b1, ALU, 7, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    chk("wb_collide_retry", {31'd0, obs_ready}, 32'd1);

    // Flush of a hazard-free instruction.
    step(mk(1'b1, ALU, 8, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b1);
    chk("flush_disp", {30'd0, disp_valid}, 32'd0);
    chk("flush_x8",   {31'd0, sb_pending[8]}, 32'd0);

    // Write to x0 neither pends nor books WB.
    step(mk(1'b1, LSU, 0, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    chk("x0_not_pending", {31'd0, sb_pending[0]}, 32'd0);
    idle();
    step(mk(1'b1, ALU, 10, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    chk("x0_no_slot", {31'd0, obs_ready}, 32'd1);

    // Reset with x3 pending and slot[2] booked; x3's late WB must be harmless.
    step(mk(1'b1, LSU, 3, 0, 0, 1'b0, 1'b0, 1'b1), 2'b11, 1'b0);
    idle();
    reset_pulse("midrst");
    for (int i = 0; i < 4; i++) idle();
    chk("post_rst_pending", sb_pending, 32'd0);

    // Random traffic with occasional asynchronous reset.
    for (int n = 0; n < 1500; n++) begin
      q = mk($urandom_range(0, 3) != 0, 2'(1 << $urandom_range(0, 1)),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4) != 0);
      prdy = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      step(q, prdy, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) reset_pulse("rndrst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
